// File: rtl/adc_l2_sched_pkg.sv
// adc_l2_sched_pkg
// Shared types and constants for the ADC-to-L2 write scheduler.
//   ch_state_e     : per-channel transfer state (IDLE / ACTIVE)
//   BYTES_PER_BEAT : bytes written to L2 per accepted sample word
package adc_l2_sched_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_e;

    localparam int BYTES_PER_BEAT = 4;

endpackage

// File: rtl/adc_rr_arb.sv
// adc_rr_arb
// Round-robin arbiter. The search for a grant begins at the priority pointer;
// after a grant to channel k has been used, the pointer moves to k+1 (mod N).
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   req_i         : request vector, one bit per channel
//   advance_i     : the current grant is being consumed this cycle
//   gnt_o         : one-hot grant (all zero when no request is pending)
module adc_rr_arb #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] cand;
    logic [PW-1:0] next_ptr;

    // Scan from the lowest priority offset to the highest so that the last
    // hit (offset 0 relative to the pointer) is the one that survives.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr_q) + i) % N);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

    assign next_ptr = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q <= '0;
        end else if (advance_i && (|req_i)) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/adc_l2_wr_sched.sv
// adc_l2_wr_sched
// Schedules sample words from N ADC channel streams into L2 memory through a
// single one-beat output register. Each channel owns an address/size window;
// a round-robin arbiter picks one valid ACTIVE channel per free output slot.
// Optional feature: define ADC_L2_SCHED_DROP_CNT_EN to get per-channel 8-bit
// saturating counters of samples discarded while the channel is IDLE.
// Ports:
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   cfg_rx_startaddr_i   : N x AW start byte address
//   cfg_rx_size_i        : N x TS transfer size in bytes
//   cfg_rx_continuous_i  : N reload-on-completion enables
//   cfg_rx_en_i          : N start pulses
//   cfg_rx_clr_i         : N abort pulses
//   cfg_rx_en_o          : N channel-active flags
//   cfg_rx_curr_addr_o   : N x AW next write address
//   cfg_rx_bytes_left_o  : N x TS bytes remaining
//   ch_done_evt_o        : N one-cycle transfer-complete pulses
//   drop_cnt_o           : N x 8 dropped-sample counts
//   ch_valid_i/ch_data_i : N sample streams
//   ch_ready_o           : N stream ready (combinational)
//   l2_req_o/l2_gnt_i    : L2 write handshake
//   l2_addr_o/l2_data_o  : L2 write address and data
module adc_l2_wr_sched
    import adc_l2_sched_pkg::*;
#(
    parameter int ADC_NUM_CHS    = 8,
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic [ADC_NUM_CHS*L2_AWIDTH_NOAL-1:0]  cfg_rx_startaddr_i,
    input  logic [ADC_NUM_CHS*TRANS_SIZE-1:0]      cfg_rx_size_i,
    input  logic [ADC_NUM_CHS-1:0]                 cfg_rx_continuous_i,
    input  logic [ADC_NUM_CHS-1:0]                 cfg_rx_en_i,
    input  logic [ADC_NUM_CHS-1:0]                 cfg_rx_clr_i,
    output logic [ADC_NUM_CHS-1:0]                 cfg_rx_en_o,
    output logic [ADC_NUM_CHS*L2_AWIDTH_NOAL-1:0]  cfg_rx_curr_addr_o,
    output logic [ADC_NUM_CHS*TRANS_SIZE-1:0]      cfg_rx_bytes_left_o,
    output logic [ADC_NUM_CHS-1:0]                 ch_done_evt_o,
    output logic [ADC_NUM_CHS*8-1:0]               drop_cnt_o,
    input  logic [ADC_NUM_CHS-1:0]                 ch_valid_i,
    input  logic [ADC_NUM_CHS*DATA_WIDTH-1:0]      ch_data_i,
    output logic [ADC_NUM_CHS-1:0]                 ch_ready_o,
    output logic                                   l2_req_o,
    input  logic                                   l2_gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0]              l2_addr_o,
    output logic [DATA_WIDTH-1:0]                  l2_data_o
);

    localparam int N  = ADC_NUM_CHS;
    localparam int AW = L2_AWIDTH_NOAL;
    localparam int TS = TRANS_SIZE;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW-1:0] ADDR_STEP = AW'(BYTES_PER_BEAT);
    localparam logic [TS-1:0] SIZE_STEP = TS'(BYTES_PER_BEAT);

    ch_state_e      state_q [N];
    logic [AW-1:0]  addr_q  [N];
    logic [TS-1:0]  left_q  [N];
    logic [N-1:0]   done_q;

    logic [AW-1:0]  start_aligned [N];
    logic [TS-1:0]  size_aligned  [N];
    logic [N-1:0]   active;
    logic [N-1:0]   en_accept;
    logic [N-1:0]   arb_req;
    logic [N-1:0]   arb_gnt;
    logic [N-1:0]   take;
    logic           load_en;
    logic           grant_any;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_data;
    logic           unused_low_bits;

    // Addresses and sizes are word aligned; the two low bits are ignored.
    always_comb begin
        active          = '0;
        en_accept       = '0;
        start_aligned   = '{default: '0};
        size_aligned    = '{default: '0};
        unused_low_bits = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i]        = (state_q[i] == ACTIVE);
            start_aligned[i] = {cfg_rx_startaddr_i[i*AW+2 +: AW-2], 2'b00};
            size_aligned[i]  = {cfg_rx_size_i[i*TS+2 +: TS-2], 2'b00};
            en_accept[i]     = !active[i] && cfg_rx_en_i[i] && !cfg_rx_clr_i[i]
                               && (size_aligned[i] != '0);
            unused_low_bits  = unused_low_bits
                               ^ (^cfg_rx_startaddr_i[i*AW +: 2])
                               ^ (^cfg_rx_size_i[i*TS +: 2]);
        end
    end

    // A channel being cleared does not compete, so an abort never races
    // with a beat update of the same channel.
    assign arb_req   = ch_valid_i & active & ~cfg_rx_clr_i;
    assign grant_any = |arb_req;
    assign load_en   = !l2_req_o || l2_gnt_i;
    assign take      = arb_gnt & {N{load_en}};
    assign ch_ready_o = ~active | take;

    adc_rr_arb #(
        .N (N)
    ) i_arb (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .req_i     (arb_req),
        .advance_i (load_en),
        .gnt_o     (arb_gnt)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = addr_q[i];
                sel_data = ch_data_i[i*DW +: DW];
            end
        end
    end

    // Output register: holds its beat until granted; refills in the same
    // cycle as the grant so one beat per cycle is sustained.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            l2_req_o  <= 1'b0;
            l2_addr_o <= '0;
            l2_data_o <= '0;
        end else if (load_en) begin
            l2_req_o <= grant_any;
            if (grant_any) begin
                l2_addr_o <= sel_addr;
                l2_data_o <= sel_data;
            end
        end
    end

    // Per-channel window tracking. A continuous reload with a configured
    // size below one beat falls back to IDLE instead of underflowing.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            done_q <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                addr_q[i]  <= '0;
                left_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                done_q[i] <= 1'b0;
                if (cfg_rx_clr_i[i]) begin
                    state_q[i] <= IDLE;
                    left_q[i]  <= '0;
                end else if (en_accept[i]) begin
                    state_q[i] <= ACTIVE;
                    addr_q[i]  <= start_aligned[i];
                    left_q[i]  <= size_aligned[i];
                end else if (take[i]) begin
                    if (left_q[i] == SIZE_STEP) begin
                        done_q[i] <= 1'b1;
                        if (cfg_rx_continuous_i[i] && (size_aligned[i] != '0)) begin
                            addr_q[i] <= start_aligned[i];
                            left_q[i] <= size_aligned[i];
                        end else begin
                            state_q[i] <= IDLE;
                            addr_q[i]  <= addr_q[i] + ADDR_STEP;
                            left_q[i]  <= '0;
                        end
                    end else begin
                        addr_q[i] <= addr_q[i] + ADDR_STEP;
                        left_q[i] <= left_q[i] - SIZE_STEP;
                    end
                end
            end
        end
    end

    always_comb begin
        cfg_rx_curr_addr_o  = '0;
        cfg_rx_bytes_left_o = '0;
        for (int i = 0; i < N; i++) begin
            cfg_rx_curr_addr_o[i*AW +: AW]  = addr_q[i];
            cfg_rx_bytes_left_o[i*TS +: TS] = left_q[i];
        end
    end

    assign cfg_rx_en_o   = active;
    assign ch_done_evt_o = done_q;

`ifdef ADC_L2_SCHED_DROP_CNT_EN
    logic [7:0] drop_q [N];

    // Accepting a new transfer restarts the count for that channel.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (en_accept[i]) begin
                    drop_q[i] <= '0;
                end else if (!active[i] && ch_valid_i[i] && (drop_q[i] != 8'hFF)) begin
                    drop_q[i] <= drop_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        drop_cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            drop_cnt_o[i*8 +: 8] = drop_q[i];
        end
    end
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_adc_l2_wr_sched.sv
// tb_adc_l2_wr_sched
// Directed-vector bench for adc_l2_wr_sched. Expected L2 beats are queued as
// stimulus is issued; a monitor pops and compares on every l2_req_o & l2_gnt_i.
module tb_adc_l2_wr_sched;

    localparam int N  = 8;
    localparam int AW = 12;
    localparam int TS = 16;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic              clk_i;
    logic              rstn_i;
    logic [N*AW-1:0]   cfg_rx_startaddr_i;
    logic [N*TS-1:0]   cfg_rx_size_i;
    logic [N-1:0]      cfg_rx_continuous_i;
    logic [N-1:0]      cfg_rx_en_i;
    logic [N-1:0]      cfg_rx_clr_i;
    logic [N-1:0]      cfg_rx_en_o;
    logic [N*AW-1:0]   cfg_rx_curr_addr_o;
    logic [N*TS-1:0]   cfg_rx_bytes_left_o;
    logic [N-1:0]      ch_done_evt_o;
    logic [N*8-1:0]    drop_cnt_o;
    logic [N-1:0]      ch_valid_i;
    logic [N*DW-1:0]   ch_data_i;
    logic [N-1:0]      ch_ready_o;
    logic              l2_req_o;
    logic              l2_gnt_i;
    logic [AW-1:0]     l2_addr_o;
    logic [DW-1:0]     l2_data_o;

    beat_t sb_q [$];
    beat_t mon_exp;
    int    checks;
    int    errors;
    int    done_seen [N];
    int    exp_done  [N];
    logic [7:0] exp_drop;

    adc_l2_wr_sched #(
        .ADC_NUM_CHS    (N),
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (TS),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .cfg_rx_startaddr_i  (cfg_rx_startaddr_i),
        .cfg_rx_size_i       (cfg_rx_size_i),
        .cfg_rx_continuous_i (cfg_rx_continuous_i),
        .cfg_rx_en_i         (cfg_rx_en_i),
        .cfg_rx_clr_i        (cfg_rx_clr_i),
        .cfg_rx_en_o         (cfg_rx_en_o),
        .cfg_rx_curr_addr_o  (cfg_rx_curr_addr_o),
        .cfg_rx_bytes_left_o (cfg_rx_bytes_left_o),
        .ch_done_evt_o       (ch_done_evt_o),
        .drop_cnt_o          (drop_cnt_o),
        .ch_valid_i          (ch_valid_i),
        .ch_data_i           (ch_data_i),
        .ch_ready_o          (ch_ready_o),
        .l2_req_o            (l2_req_o),
        .l2_gnt_i            (l2_gnt_i),
        .l2_addr_o           (l2_addr_o),
        .l2_data_o           (l2_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] dataOf(input int k);
        return 32'hA5A5_0000 + DW'(k);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] currAddr(input int k);
        return cfg_rx_curr_addr_o[k*AW +: AW];
    endfunction

    function automatic logic [TS-1:0] bytesLeft(input int k);
        return cfg_rx_bytes_left_o[k*TS +: TS];
    endfunction

    // Scoreboard monitor and done-pulse counter
    always @(negedge clk_i) begin
        if (rstn_i && l2_req_o && l2_gnt_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got addr 0x%0h data 0x%0h expected no beat", l2_addr_o, l2_data_o);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("beat_addr", 64'(l2_addr_o), 64'(mon_exp.addr));
                checkOutput("beat_data", 64'(l2_data_o), 64'(mon_exp.data));
            end
        end
        for (int k = 0; k < N; k++) begin
            if (ch_done_evt_o[k]) done_seen[k]++;
        end
    end

    task automatic configCh(input int ch, input logic [AW-1:0] start, input logic [TS-1:0] size, input logic cont);
        cfg_rx_startaddr_i[ch*AW +: AW] = start;
        cfg_rx_size_i[ch*TS +: TS]      = size;
        cfg_rx_continuous_i[ch]         = cont;
    endtask

    task automatic pulseEn(input logic [N-1:0] mask);
        cfg_rx_en_i = mask;
        @(posedge clk_i); #1;
        cfg_rx_en_i = '0;
    endtask

    task automatic pulseClr(input logic [N-1:0] mask);
        cfg_rx_clr_i = mask;
        @(posedge clk_i); #1;
        cfg_rx_clr_i = '0;
    endtask

    task automatic pushBeat(input logic [AW-1:0] addr, input int ch);
        beat_t b;
        b.addr = addr;
        b.data = dataOf(ch);
        sb_q.push_back(b);
    endtask

    // Hold valid on each channel in mask until n samples were accepted by an
    // ACTIVE channel, then drop valid right after the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] mask, input int n);
        int cnt [N];
        logic [N-1:0] pend;
        int budget;
        pend   = mask;
        budget = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        ch_valid_i = ch_valid_i | mask;
        while (pend != '0 && budget < 200) begin
            @(negedge clk_i);
            budget++;
            for (int k = 0; k < N; k++) begin
                if (pend[k] && ch_valid_i[k] && ch_ready_o[k] && cfg_rx_en_o[k]) cnt[k]++;
            end
            @(posedge clk_i); #1;
            for (int k = 0; k < N; k++) begin
                if (pend[k] && cnt[k] >= n) begin
                    ch_valid_i[k] = 1'b0;
                    pend[k]       = 1'b0;
                end
            end
        end
        if (pend != '0) begin
            checks++;
            errors++;
            $display("[TB] FAIL stim_timeout: channels 0x%0h still pending, expected none", pend);
            ch_valid_i = ch_valid_i & ~mask;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks              = 0;
        errors              = 0;
        rstn_i              = 1'b0;
        cfg_rx_startaddr_i  = '0;
        cfg_rx_size_i       = '0;
        cfg_rx_continuous_i = '0;
        cfg_rx_en_i         = '0;
        cfg_rx_clr_i        = '0;
        ch_valid_i          = '0;
        l2_gnt_i            = 1'b1;
        for (int k = 0; k < N; k++) begin
            ch_data_i[k*DW +: DW] = dataOf(k);
            done_seen[k] = 0;
        end
        exp_done = '{1, 2, 1, 0, 1, 1, 1, 0};

        // Reset state
        @(negedge clk_i);
        checkOutput("rst_l2_req", 64'(l2_req_o), 64'd0);
        checkOutput("rst_ready", 64'(ch_ready_o), 64'hFF);
        checkOutput("rst_en_o", 64'(cfg_rx_en_o), 64'd0);
        checkOutput("rst_curr_addr", 64'(|cfg_rx_curr_addr_o), 64'd0);
        checkOutput("rst_bytes_left", 64'(|cfg_rx_bytes_left_o), 64'd0);
        checkOutput("rst_drop", drop_cnt_o, 64'd0);
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Ch0: three beats then completion
        $display("[TB] single channel, size 12");
        configCh(0, 12'h100, 16'd12, 1'b0);
        pulseEn(8'h01);
        checkOutput("ch0_active", 64'(cfg_rx_en_o[0]), 64'd1);
        checkOutput("ch0_bytes_left", 64'(bytesLeft(0)), 64'd12);
        pushBeat(12'h100, 0);
        pushBeat(12'h104, 0);
        pushBeat(12'h108, 0);
        applyStimulus(8'h01, 3);
        waitDrain();
        checkOutput("ch0_idle", 64'(cfg_rx_en_o[0]), 64'd0);
        checkOutput("ch0_end_addr", 64'(currAddr(0)), 64'h10C);
        checkOutput("ch0_end_left", 64'(bytesLeft(0)), 64'd0);

        // Ch2 and ch5 alternate under round robin
        $display("[TB] round robin ch2/ch5");
        configCh(2, 12'h200, 16'd16, 1'b0);
        configCh(5, 12'h300, 16'd16, 1'b0);
        pulseEn(8'h24);
        for (int b = 0; b < 4; b++) begin
            pushBeat(12'h200 + 12'(4*b), 2);
            pushBeat(12'h300 + 12'(4*b), 5);
        end
        applyStimulus(8'h24, 4);
        waitDrain();

        // Ch6 with grant held low for three cycles
        $display("[TB] grant stall");
        configCh(6, 12'h500, 16'd16, 1'b0);
        l2_gnt_i = 1'b0;
        pulseEn(8'h40);
        for (int b = 0; b < 4; b++) pushBeat(12'h500 + 12'(4*b), 6);
        ch_valid_i[6] = 1'b1;
        @(posedge clk_i); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checkOutput("stall_req", 64'(l2_req_o), 64'd1);
            checkOutput("stall_addr", 64'(l2_addr_o), 64'h500);
            checkOutput("stall_data", 64'(l2_data_o), 64'(dataOf(6)));
            checkOutput("stall_ready", 64'(ch_ready_o), 64'hBF);
            checkOutput("stall_curr_addr", 64'(currAddr(6)), 64'h504);
        end
        @(posedge clk_i); #1;
        l2_gnt_i = 1'b1;
        applyStimulus(8'h40, 3);
        waitDrain();

        // Ch1 continuous reload
        $display("[TB] continuous ch1");
        configCh(1, 12'h040, 16'd8, 1'b1);
        pulseEn(8'h02);
        pushBeat(12'h040, 1);
        pushBeat(12'h044, 1);
        pushBeat(12'h040, 1);
        pushBeat(12'h044, 1);
        applyStimulus(8'h02, 4);
        waitDrain();
        checkOutput("ch1_still_active", 64'(cfg_rx_en_o[1]), 64'd1);
        checkOutput("ch1_reload_addr", 64'(currAddr(1)), 64'h040);
        checkOutput("ch1_reload_left", 64'(bytesLeft(1)), 64'd8);
        configCh(1, 12'h080, 16'd8, 1'b1);
        pulseEn(8'h02);
        checkOutput("ch1_en_while_active", 64'(currAddr(1)), 64'h040);
        pulseClr(8'h02);
        checkOutput("ch1_clr_idle", 64'(cfg_rx_en_o[1]), 64'd0);
        checkOutput("ch1_clr_left", 64'(bytesLeft(1)), 64'd0);

        // Ch3 clear and enable in the same cycle
        $display("[TB] clr vs en on ch3");
        configCh(3, 12'h600, 16'd16, 1'b0);
        cfg_rx_en_i   = 8'h08;
        cfg_rx_clr_i  = 8'h08;
        ch_valid_i[3] = 1'b1;
        @(posedge clk_i); #1;
        cfg_rx_en_i  = '0;
        cfg_rx_clr_i = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            checkOutput("ch3_no_req", 64'(l2_req_o), 64'd0);
        end
        checkOutput("ch3_idle", 64'(cfg_rx_en_o[3]), 64'd0);
        checkOutput("ch3_ready_idle", 64'(ch_ready_o[3]), 64'd1);
        @(posedge clk_i); #1;
        ch_valid_i[3] = 1'b0;

        // Ch7 size below one beat is ignored
        configCh(7, 12'h000, 16'd3, 1'b0);
        pulseEn(8'h80);
        checkOutput("ch7_small_size", 64'(cfg_rx_en_o[7]), 64'd0);

        // Ch4 drop counter then a wrapping single-beat transfer
        $display("[TB] drop counter and address wrap on ch4");
        ch_valid_i[4] = 1'b1;
        repeat (300) @(posedge clk_i);
        #1;
        ch_valid_i[4] = 1'b0;
`ifdef ADC_L2_SCHED_DROP_CNT_EN
        exp_drop = 8'd255;
`else
        exp_drop = 8'd0;
`endif
        checkOutput("ch4_drop_sat", 64'(drop_cnt_o[4*8 +: 8]), 64'(exp_drop));
        configCh(4, 12'hFFC, 16'd4, 1'b0);
        pulseEn(8'h10);
        checkOutput("ch4_drop_cleared", 64'(drop_cnt_o[4*8 +: 8]), 64'd0);
        pushBeat(12'hFFC, 4);
        applyStimulus(8'h10, 1);
        waitDrain();
        checkOutput("ch4_wrap_addr", 64'(currAddr(4)), 64'h000);
        checkOutput("ch4_idle", 64'(cfg_rx_en_o[4]), 64'd0);

        // Reset with a beat pending in the output register
        $display("[TB] reset mid transfer");
        configCh(0, 12'h900, 16'd16, 1'b0);
        l2_gnt_i = 1'b0;
        pulseEn(8'h01);
        ch_valid_i[0] = 1'b1;
        @(posedge clk_i); #1;
        ch_valid_i[0] = 1'b0;
        @(negedge clk_i);
        checkOutput("pending_req", 64'(l2_req_o), 64'd1);
        checkOutput("pending_addr", 64'(l2_addr_o), 64'h900);
        rstn_i = 1'b0;
        #2;
        checkOutput("midrst_ready", 64'(ch_ready_o), 64'hFF);
        checkOutput("midrst_req", 64'(l2_req_o), 64'd0);
        @(negedge clk_i);
        rstn_i   = 1'b1;
        l2_gnt_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checkOutput("postrst_no_req", 64'(l2_req_o), 64'd0);
        end
        checkOutput("postrst_drop", drop_cnt_o, 64'd0);
        checkOutput("postrst_ch4_addr", 64'(currAddr(4)), 64'h000);
        checkOutput("postrst_ch0_active", 64'(cfg_rx_en_o[0]), 64'd0);

        // Done pulses per channel across the whole run
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("done_count_ch%0d", k), 64'(done_seen[k]), 64'(exp_done[k]));
        end
        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
